// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Ports: clk, rst (async high), start/ex_adv/op/src_a/src_b from EX,
// flush from MEM1; isbusy (comb), hi/lo (registered), done (write pulse).
module hilo_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ex_adv,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        isbusy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [32:0] opa_q;
  logic [32:0] opb_q;
  logic [63:0] prod_q;
  logic [31:0] rem_q;
  logic        qsign_q;
  logic        rsign_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        sgn;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] pa;
  logic [63:0] pb;
  logic [63:0] prod_d;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  assign accept = start & ex_adv & ~flush & (state_q == S_IDLE);

  // op 0 (MULT) and op 2 (DIV) are the signed forms
  assign sgn   = ~op[0];
  assign abs_a = (sgn & src_a[31]) ? -src_a : src_a;
  assign abs_b = (sgn & src_b[31]) ? -src_b : src_b;

  // 33x33 signed product; low 64 bits of a 64-bit multiply are exact
  assign pa     = {{31{opa_q[32]}}, opa_q};
  assign pb     = {{31{opb_q[32]}}, opb_q};
  assign prod_d = pa * pb;

  // restoring step: shift next dividend bit into the partial remainder;
  // a borrow out of bit 32 means the divisor did not fit
  assign trial = {rem_q, opa_q[31]};
  assign diff  = trial - {1'b0, opb_q[31:0]};
  assign qbit  = ~diff[32];
  assign rem_d = qbit ? diff[31:0] : trial[31:0];
  assign quo_d = {opa_q[30:0], qbit};

  assign isbusy = (state_q != S_IDLE) | (accept & ~op[2]);
  assign done   = ~flush &
                  (((state_q == S_MUL) & (cnt_q == 6'd1)) |
                   (state_q == S_FIX));
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op)
              3'd0, 3'd1: begin
                opa_q   <= {sgn & src_a[31], src_a};
                opb_q   <= {sgn & src_b[31], src_b};
                cnt_q   <= '0;
                state_q <= S_MUL;
              end
              3'd2, 3'd3: begin
                opa_q   <= {1'b0, abs_a};
                opb_q   <= {1'b0, abs_b};
                rem_q   <= '0;
                qsign_q <= sgn & (src_a[31] ^ src_b[31]);
                rsign_q <= sgn & src_a[31];
                cnt_q   <= '0;
                state_q <= S_DIV;
              end
              3'd4: hi_q <= src_a;
              3'd5: lo_q <= src_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 6'd0) begin
            prod_q <= prod_d;
            cnt_q  <= 6'd1;
          end else begin
            hi_q    <= prod_q[63:32];
            lo_q    <= prod_q[31:0];
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            rem_q       <= rem_d;
            opa_q[31:0] <= quo_d;
            cnt_q       <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            lo_q <= qsign_q ? -opa_q[31:0] : opa_q[31:0];
            hi_q <= rsign_q ? -rem_q : rem_q;
          end
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed + randomized check of hilo_mdu against an
// arithmetic reference model of MIPS HI/LO semantics.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ex_adv;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        isbusy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  hilo_mdu dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ex_adv (ex_adv),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .isbusy (isbusy),
    .hi     (hi),
    .lo     (lo),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // returns {HI, LO}
  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] am;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = '0;
    r  = '0;
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 0) begin
          am = a[31] ? -a : a;
          q  = a[31] ? -32'hFFFFFFFF : 32'hFFFFFFFF;
          r  = a[31] ? -am : am;
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end
        return {r, q};
      end
      3'd3: begin
        if (b == 0) begin
          q = 32'hFFFFFFFF;
          r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Entered at posedge+1 of the issue cycle; returns at posedge+2 of the
  // first cycle isbusy is low again, so the next op can issue there.
  task automatic run_op(input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] r;
    int lat;
    start  = 1'b1;
    ex_adv = 1'b1;
    op     = o;
    src_a  = a;
    src_b  = b;
    #1;
    chk("busy_issue", isbusy, (o < 4));
    chk("done_issue", done, 0);
    tick;
    start = 1'b0;
    if (o < 4) begin
      r   = model(o, a, b);
      lat = (o < 2) ? 3 : 34;
      for (int c = 1; c < lat; c++) begin
        if (c > 1) tick;
        #1;
        chk("busy_run", isbusy, 1);
        chk("done_run", done, (c == lat - 1));
        chk("hi_hold", hi, hi_m);
      end
      tick;
      hi_m = r[63:32];
      lo_m = r[31:0];
    end else begin
      if (o == 3'd4) hi_m = a;
      if (o == 3'd5) lo_m = a;
    end
    #1;
    chk("busy_end", isbusy, 0);
    chk("hi", hi, hi_m);
    chk("lo", lo, lo_m);
  endtask

  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                              32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9};

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 20);
      2: return corner[$urandom_range(0, 5)];
      default: return -$urandom_range(1, 20);
    endcase
  endfunction

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    ex_adv = 1'b0;
    flush  = 1'b0;
    op     = '0;
    src_a  = '0;
    src_b  = '0;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", isbusy, 0);
    chk("rst_done", done, 0);
    tick;
    rst = 1'b0;
    tick;

    run_op(3'd0, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    run_op(3'd2, -32'd7, 32'd2);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'd100, 32'd7);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(3'd3, 32'h1234, 32'd0);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h1234);
    run_op(3'd2, -32'd5, 32'd0);
    chk("div0_lo", lo, 32'h1);
    chk("div0_hi", hi, 32'hFFFFFFFB);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    // flush at cycle 10 of a DIV, new DIV issued at cycle 11
    start  = 1'b1;
    ex_adv = 1'b1;
    op     = 3'd2;
    src_a  = 32'd1000;
    src_b  = 32'd3;
    tick;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      #1;
      chk("fl_done", done, 0);
      tick;
    end
    flush = 1'b1;
    #1;
    chk("fl_busy10", isbusy, 1);
    chk("fl_done10", done, 0);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_busy11", isbusy, 0);
    chk("fl_hi", hi, hi_m);
    chk("fl_lo", lo, lo_m);
    run_op(3'd2, -32'd100, 32'd9);

    // flush together with start from idle: ignored
    start  = 1'b1;
    ex_adv = 1'b1;
    flush  = 1'b1;
    op     = 3'd4;
    src_a  = 32'h55;
    #1;
    chk("fs_busy", isbusy, 0);
    tick;
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("fs_hi", hi, hi_m);

    // start held without ex_adv
    start  = 1'b1;
    ex_adv = 1'b0;
    op     = 3'd3;
    src_a  = 32'd77;
    src_b  = 32'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_busy", isbusy, 0);
      tick;
    end
    run_op(3'd3, 32'd77, 32'd5);
    #1;
    chk("hold_once", isbusy, 0);

    run_op(3'd4, 32'hDEADBEEF, 32'd0);
    run_op(3'd5, 32'h1, 32'd0);
    chk("mthi", hi, 32'hDEADBEEF);
    chk("mtlo", lo, 32'h1);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
      if ($urandom_range(0, 1) == 1) tick;
    end

    // reset mid-DIV
    start  = 1'b1;
    ex_adv = 1'b1;
    op     = 3'd2;
    src_a  = 32'd50;
    src_b  = 32'd4;
    tick;
    start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    #1;
    chk("mrst_hi", hi, 0);
    chk("mrst_lo", lo, 0);
    chk("mrst_busy", isbusy, 0);
    chk("mrst_done", done, 0);
    hi_m = '0;
    lo_m = '0;
    tick;
    rst = 1'b0;
    tick;
    run_op(3'd0, 32'd6, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Iterative multiply/divide unit owning the HI/LO registers of the MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage. Runs multi-cycle operations in the background and drives `isbusy`, which the stall unit combines with `RHL_visit` to hold MFHI/MFLO and later HI/LO writers. Exceptions signalled from MEM1 abort an in-flight operation.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  EX holds a valid HI/LO instruction.
- `ex_adv`  in  1  EX stage advancing this cycle (EX_MEM1Wr). `start` is accepted only when `start & ex_adv & ~flush & state==IDLE`.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 treated as no-op.
- `src_a`  in  32  rs operand (dividend / multiplicand / MTHI·MTLO data).
- `src_b`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  MEM1_ee; kill in-flight operation.
- `isbusy`  out  1  HI/LO result pending.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `done`  out  1  one-cycle pulse on the cycle HI/LO are written by MUL/DIV.

## Operation
- States: IDLE, MUL, DIV, FIX. Counter `cnt[5:0]`.
- IDLE, accepted op 0/1:
  - Latch operands and signedness; go to MUL, `cnt=0`.
  - MUL takes 2 cycles: cycle 1 registers the 64-bit product, cycle 2 writes {HI,LO} and returns to IDLE.
  - Signed uses two's-complement 33×33; unsigned zero-extends.
- IDLE, accepted op 2/3:
  - Latch |a|, |b| (DIVU: raw values), `qsign=a[31]^b[31]`, `rsign=a[31]` (signed only); go to DIV, `cnt=0`.
  - DIV: one restoring step per cycle for 32 cycles (`cnt` 0..31), 33-bit partial remainder, quotient shifted in LSB-first from the dividend MSB. After `cnt==31`, go to FIX.
  - FIX (1 cycle): negate quotient if `qsign`, negate remainder if `rsign`; LO=quotient, HI=remainder; return to IDLE.
- Divide by zero is not special-cased; the result is the natural core result.
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV x/0: magnitude quotient 0xFFFFFFFF, remainder |x|, then sign fixup (x=-5: LO=0x00000001, HI=0xFFFFFFFB).
- Signed overflow, 0x80000000/-1: LO=0x80000000, HI=0.
- IDLE, accepted op 4/5: write HI (op 4) or LO (op 5) from `src_a` at that edge. No state change, no `done`.
- `isbusy = (state!=IDLE) | (start & ex_adv & ~flush & state==IDLE & op∈{0..3})`. It is combinational so a dependent MFHI in ID stalls in the issue cycle.
- `flush` while state≠IDLE: next state IDLE, HI/LO unchanged, no `done`. `flush` and `start` in the same cycle: start ignored.
- `start` while state≠IDLE: ignored; the stall unit must prevent this.

## Timing
- Reset: state=IDLE, `cnt=0`, `hi=0`, `lo=0`, `done=0`, `isbusy=0`. Asserting `rst` mid-operation discards it.
- Issue edge at end of cycle 0.
- MULT/MULTU:
  - `isbusy` high cycles 0–2.
  - `done` high in cycle 2.
  - New `hi`/`lo` visible cycle 3.
- DIV/DIVU:
  - `isbusy` high cycles 0–33 (cycles 1–32 in DIV, cycle 33 in FIX).
  - `done` high in cycle 33.
  - New `hi`/`lo` visible cycle 34.
- MTHI/MTLO: `isbusy` stays 0; new value visible cycle 1.
- A back-to-back op can be accepted in the first cycle `isbusy` is low, i.e. cycle 3 after MULT, cycle 34 after DIV.
- `hi`/`lo` are registered outputs; they never change except on a write edge.

## Test plan
- MULT: `src_a`=0xFFFFFFFE (-2), `src_b`=3 → `isbusy` 1 for cycles 0–2; cycle 3 HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV: -7 / 2 → cycle 34 LO=0xFFFFFFFD, HI=0xFFFFFFFF, `done` pulse in cycle 33. DIVU 100/7 → LO=14, HI=2.
- Divide by zero: DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234. Overflow: DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- `flush` at cycle 10 of a DIV → `isbusy` low from cycle 11, HI/LO keep their prior values, no `done`. A DIV issued at cycle 11 completes normally.
- `start`=1 with `ex_adv`=0 for 3 cycles, then `ex_adv`=1 → exactly one operation issued; `isbusy` low during the held cycles.
- MTHI 0xDEADBEEF from idle, then MTLO 0x1 next cycle → HI=0xDEADBEEF in cycle 1, LO=0x1 in cycle 2, `isbusy` never asserted. `rst` mid-DIV → all outputs 0 immediately.
